parity_sched: RTL
=================

Name: parity_sched

Overview:
- Shares one bit-serial parity encoder between two requesters using round-robin arbitration.
- Each request supplies a payload word and a parity mode. The block writes the parity bit into the MSB of the word and returns the word with the requester ID.
- Sits between producers of raw words (e.g. register or bus write paths) and any consumer that needs parity-protected words.
- Sequential replacement for the combinational parity generator: trades latency for area, with a single XOR accumulator.

Parameters:
- DATA_W, 31, payload width. The word width is DATA_W+1 and the parity bit occupies bit DATA_W. Legal range is 2..63.
- CNT_W, $clog2(DATA_W), width of the bit-position counter (derived, do not override).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high; clears all state immediately.
- req0_valid, input, 1, requester 0 has a word.
- req0_data, input, DATA_W+1, word from requester 0; bit DATA_W is ignored.
- req0_odd, input, 1, 1 = odd parity over the full output word, 0 = even parity.
- req0_ready, output, 1, requester 0 accepted this cycle.
- req1_valid, req1_data, req1_odd, req1_ready: same as requester 0, for requester 1.
- out_valid, output, 1, result available.
- out_data, output, DATA_W+1, encoded word.
- out_id, output, 1, requester index of the result.
- out_ready, input, 1, consumer accepts the result.

Behaviour:
- Reset values: req0_ready=0, req1_ready=0, out_valid=0, out_data=0, out_id=0, state=IDLE, last_grant=1 (so requester 0 wins the first tie), cnt=0, acc=0.
- FSM states:
  - IDLE: accept a request.
  - CALC: serial parity computation.
  - DONE: hold the result.
- IDLE:
  - Readies are combinational, high only in IDLE.
  - req0_ready = req0_valid & (!req1_valid | last_grant==1).
  - req1_ready = req1_valid & (!req0_valid | last_grant==0).
  - At most one ready is high in any cycle.
  - On a handshake, capture data[DATA_W-1:0], the mode and the id; set last_grant=id, cnt=0, acc=0; go to CALC.
- CALC: on each edge, acc ^= data[cnt] and cnt++. When cnt==DATA_W-1 at the edge, go to DONE.
  - CALC takes exactly DATA_W edges.
  - Latency: if the handshake occurs in cycle t, out_valid rises in cycle t+DATA_W+1.
- Parity bit rule: par = acc ^ mode, where acc is the XOR of the payload bits.
  - odd=1 means the total count of ones in out_data is odd.
  - odd=0 means the total count of ones in out_data is even.
- DONE:
  - out_valid=1, out_data={par, payload}, out_id=id.
  - All outputs hold stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE and clear out_valid. A new request can be accepted in the following cycle; there is no same-cycle bypass.
  - out_data and out_id keep their last value after the transfer; they are only meaningful while out_valid=1.
- Requests are ignored outside IDLE: valid may stay high, and ready stays 0.
- Simultaneous valids: the requester not served last wins, which gives strict alternation under continuous contention. Neither requester can starve.
- Input bit DATA_W never influences the result.
- Reset mid-operation (CALC or DONE): the in-flight word is discarded with no output, and the state returns to IDLE with reset values.
- Counter: CNT_W bits, never wraps in use because the terminal compare happens at DATA_W-1.

Decomposition:
- Package parity_sched_pkg:
  - state encodings S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2;
  - ID constants ID0=1'b0, ID1=1'b1.
- Sub-module parity_serial_core contains the payload register, cnt, acc, start/busy/done flags and par output.
- The top level keeps the arbiter, the FSM and the output register.

Test Plan:
- Requester 0 sends 32'h0000_0001 with odd=0 → out_data=32'h8000_0001, out_id=0; out_valid rises exactly 32 cycles after the handshake cycle.
- Requester 1 sends 32'h7FFF_FFFF with odd=0 → out_data=32'hFFFF_FFFF. The same word with odd=1 → 32'h7FFF_FFFF.
- Requester 0 sends 32'h8000_0000 with odd=1, so only ignored bit 31 is set → out_data=32'h8000_0000. The same word with odd=0 → 32'h0000_0000.
- Both valids held high for 4 transactions with out_ready=1 → out_id sequence is 0,1,0,1, and the readies are never high together.
- out_ready held 0 for 10 cycles in DONE → out_valid, out_data and out_id stay stable, and both readies stay 0. Then out_ready=1 for one cycle → out_valid drops and the next request is accepted the following cycle.
- reset pulsed at CALC cycle 15 → out_valid stays 0 with no spurious output; the next request from requester 0 wins arbitration, per the last_grant reset value.

Source files
------------

// File: rtl/parity_sched_pkg.sv
// Shared types and constants for the round-robin serial parity scheduler.
package parity_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic ID0 = 1'b0;
    localparam logic ID1 = 1'b1;

endpackage

// File: rtl/parity_serial_core.sv
// Bit-serial parity engine: one payload bit is folded into the XOR accumulator per clock.
module parity_serial_core
    import parity_sched_pkg::*;
#(
    parameter int DATA_W = 31,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              odd,
    output logic              done,
    output logic [DATA_W-1:0] payload,
    output logic              par
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              last;

    assign last    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign done    = last;
    assign payload = data_q;
    // Includes the bit being folded this cycle, so it is final when done is high.
    assign par     = acc_q ^ data_q[cnt_q] ^ mode_q;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mode_d = mode_q;
        busy_d = busy_q;
        if (start) begin
            data_d = din;
            mode_d = odd;
            cnt_d  = '0;
            acc_d  = 1'b0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = acc_q ^ data_q[cnt_q];
            cnt_d = cnt_q + CNT_W'(1);
            if (last) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/parity_sched.sv
// Two-requester round-robin front end sharing one serial parity core; result held until taken.
module parity_sched
    import parity_sched_pkg::*;
#(
    parameter int DATA_W = 31
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [DATA_W:0] req0_data,
    input  logic            req0_odd,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DATA_W:0] req1_data,
    input  logic            req1_odd,
    output logic            req1_ready,
    output logic            out_valid,
    output logic [DATA_W:0] out_data,
    output logic            out_id,
    input  logic            out_ready
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            out_valid_q, out_valid_d;
    logic [DATA_W:0] out_data_q, out_data_d;
    logic            out_id_q, out_id_d;

    logic              core_start, core_done, core_par, core_odd;
    logic [DATA_W-1:0] core_din, core_payload;
    logic              idle, unused_msb;

    // Incoming parity slot is overwritten, so its value is deliberately dropped.
    assign unused_msb = req0_data[DATA_W] ^ req1_data[DATA_W];

    assign idle       = (state_q == S_IDLE) && !reset;
    assign req0_ready = idle && req0_valid && (!req1_valid || last_grant_q == ID1);
    assign req1_ready = idle && req1_valid && (!req0_valid || last_grant_q == ID0);
    assign core_start = req0_ready || req1_ready;
    assign core_din   = req1_ready ? req1_data[DATA_W-1:0] : req0_data[DATA_W-1:0];
    assign core_odd   = req1_ready ? req1_odd : req0_odd;

    parity_serial_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .start   (core_start),
        .din     (core_din),
        .odd     (core_odd),
        .done    (core_done),
        .payload (core_payload),
        .par     (core_par)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        case (state_q)
            S_IDLE: begin
                if (core_start) begin
                    last_grant_d = req1_ready ? ID1 : ID0;
                    state_d      = S_CALC;
                end
            end
            S_CALC: begin
                if (core_done) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = {core_par, core_payload};
                    out_id_d    = last_grant_q;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= ID0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule
